datapath_unit: RTL and testbench

DATAPATH_UNIT -- requirements
Module: datapath_unit

---
 rtl/datapath_pkg.sv | 41 ++++
 rtl/datapath_if.sv | 21 ++
 rtl/datapath_alu.sv | 26 ++
 rtl/datapath_unit.sv | 164 ++++++++++++++++
 tb/tb_datapath_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the accumulator datapath: control-word bit indices,
// ALU opcodes and memory-handshake FSM states.
package datapath_pkg;

    localparam int CTRL_W = 22;

    localparam int C_PC_INC     = 0;
    localparam int C_PC_LOAD    = 1;
    localparam int C_IR_LOAD    = 2;
    localparam int C_AC_LOAD    = 3;
    localparam int C_AC_CLEAR   = 4;
    localparam int C_MAR_FROM_PC = 5;
    localparam int C_MAR_FROM_IR = 6;
    localparam int C_MDR_FROM_AC = 7;
    localparam int C_MEM_READ   = 8;
    localparam int C_MEM_WRITE  = 9;
    localparam int C_ALU_LO     = 10;
    localparam int C_ALU_HI     = 12;
    localparam int C_AC_SHL     = 13;
    localparam int C_AC_SHR     = 14;
    localparam int C_AC_INC     = 15;
    localparam int C_RSVD_LO    = 16;

    typedef enum logic [2:0] {
        ALU_PASS_MDR = 3'd0,
        ALU_ADD      = 3'd1,
        ALU_SUB      = 3'd2,
        ALU_AND      = 3'd3,
        ALU_OR       = 3'd4,
        ALU_XOR      = 3'd5,
        ALU_NOT_AC   = 3'd6,
        ALU_PASS_AC  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/datapath_if.sv
// Memory request/acknowledge bus between the datapath (master) and memory (slave).
interface datapath_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/datapath_alu.sv
// Combinational 16-bit ALU; all arithmetic wraps modulo 2^16.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [15:0] ac_i,
    input  logic [15:0] mdr_i,
    input  alu_op_e     op_i,
    output logic [15:0] res_o
);

    always_comb begin
        res_o = mdr_i;
        case (op_i)
            ALU_PASS_MDR: res_o = mdr_i;
            ALU_ADD:      res_o = ac_i + mdr_i;
            ALU_SUB:      res_o = ac_i - mdr_i;
            ALU_AND:      res_o = ac_i & mdr_i;
            ALU_OR:       res_o = ac_i | mdr_i;
            ALU_XOR:      res_o = ac_i ^ mdr_i;
            ALU_NOT_AC:   res_o = ~ac_i;
            ALU_PASS_AC:  res_o = ac_i;
            default:      res_o = mdr_i;
        endcase
    end

endmodule

// File: rtl/datapath_unit.sv
// Microcoded accumulator datapath (PC/MAR/IR/AC/MDR) with a request/ack memory port.
// Optional: define DATAPATH_MEM_TIMEOUT_EN to abort transactions after 255 busy cycles.
module datapath_unit
    import datapath_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] bus_controller,
    output logic              IR15,
    output logic              IR14,
    output logic              AC15,
    output logic              wait_,
    datapath_if.master        mem,
    output logic              err
);

    logic pc_inc, pc_load, ir_load, ac_load, ac_clear;
    logic mar_from_pc, mar_from_ir, mdr_from_ac, mem_read, mem_write;
    logic ac_shl, ac_shr, ac_inc;
    alu_op_e alu_op;
    logic    unused_rsvd;

    assign pc_inc      = bus_controller[C_PC_INC];
    assign pc_load     = bus_controller[C_PC_LOAD];
    assign ir_load     = bus_controller[C_IR_LOAD];
    assign ac_load     = bus_controller[C_AC_LOAD];
    assign ac_clear    = bus_controller[C_AC_CLEAR];
    assign mar_from_pc = bus_controller[C_MAR_FROM_PC];
    assign mar_from_ir = bus_controller[C_MAR_FROM_IR];
    assign mdr_from_ac = bus_controller[C_MDR_FROM_AC];
    assign mem_read    = bus_controller[C_MEM_READ];
    assign mem_write   = bus_controller[C_MEM_WRITE];
    assign alu_op      = alu_op_e'(bus_controller[C_ALU_HI:C_ALU_LO]);
    assign ac_shl      = bus_controller[C_AC_SHL];
    assign ac_shr      = bus_controller[C_AC_SHR];
    assign ac_inc      = bus_controller[C_AC_INC];
    assign unused_rsvd = ^bus_controller[CTRL_W-1:C_RSVD_LO];

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d, addr_hold_q, addr_hold_d;
    logic [15:0]       ir_q, ir_d, ac_q, ac_d, mdr_q, mdr_d, wdata_hold_q, wdata_hold_d;
    logic [15:0]       alu_res;
    mem_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic              busy, start, rd_done;

    assign busy    = (state_q != IDLE);
    assign rd_done = (state_q == RD) && mem.mem_ack;

    datapath_alu u_alu (
        .ac_i  (ac_q),
        .mdr_i (mdr_q),
        .op_i  (alu_op),
        .res_o (alu_res)
    );

`ifdef DATAPATH_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'd254;
    logic [7:0] tmo_q, tmo_d;
    logic       tmo_expire;

    // Counts completed busy cycles; the 255th busy cycle without an ack aborts.
    assign tmo_d      = busy ? tmo_q + 8'd1 : 8'd0;
    assign tmo_expire = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= 8'd0;
        else       tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        pc_d = pc_q;
        if (pc_load)     pc_d = ir_q[ADDR_W-1:0];
        else if (pc_inc) pc_d = pc_q + ADDR_W'(1);

        mar_d = mar_q;
        if (mar_from_ir)      mar_d = ir_q[ADDR_W-1:0];
        else if (mar_from_pc) mar_d = pc_q;

        ir_d = ir_load ? mdr_q : ir_q;

        ac_d = ac_q;
        if (ac_clear)     ac_d = 16'd0;
        else if (ac_load) ac_d = alu_res;
        else if (ac_shl)  ac_d = {ac_q[14:0], 1'b0};
        else if (ac_shr)  ac_d = {1'b0, ac_q[15:1]};
        else if (ac_inc)  ac_d = ac_q + 16'd1;

        mdr_d = mdr_q;
        if (rd_done)          mdr_d = mem.mem_rdata;
        else if (mdr_from_ac) mdr_d = ac_q;
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read) begin
                    state_d = RD;
                    start   = 1'b1;
                end else if (mem_write) begin
                    state_d = WR;
                    start   = 1'b1;
                end
            end
            RD, WR: begin
                if (mem.mem_ack) state_d = IDLE;
`ifdef DATAPATH_MEM_TIMEOUT_EN
                else if (tmo_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // The request uses MAR/MDR as they stand in the issuing cycle, frozen until done.
    assign addr_hold_d  = start ? mar_q : addr_hold_q;
    assign wdata_hold_d = start ? mdr_q : wdata_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            mar_q        <= '0;
            ir_q         <= '0;
            ac_q         <= '0;
            mdr_q        <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
            state_q      <= IDLE;
            err_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            mar_q        <= mar_d;
            ir_q         <= ir_d;
            ac_q         <= ac_d;
            mdr_q        <= mdr_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            state_q      <= state_d;
            err_q        <= err_d;
        end
    end

    assign mem.mem_req   = busy;
    assign mem.mem_we    = (state_q == WR);
    assign mem.mem_addr  = busy ? addr_hold_q : mar_q;
    assign mem.mem_wdata = busy ? wdata_hold_q : mdr_q;

    assign wait_ = busy;
    assign err   = err_q;
    assign IR15  = ir_q[15];
    assign IR14  = ir_q[14];
    assign AC15  = ac_q[15];

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle, the monitor pops and compares.
module tb_datapath_unit;
    import datapath_pkg::*;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [21:0] bc = '0;
    logic        IR15, IR14, AC15, wait_, err;

    datapath_if #(.ADDR_W(AW)) mem_if ();

    datapath_unit #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_controller (bc),
        .IR15           (IR15),
        .IR14           (IR14),
        .AC15           (AC15),
        .wait_          (wait_),
        .mem            (mem_if),
        .err            (err)
    );

    always #5 clk = ~clk;

    localparam logic [21:0] PC_INC  = 22'(1) << C_PC_INC;
    localparam logic [21:0] PC_LOAD = 22'(1) << C_PC_LOAD;
    localparam logic [21:0] IR_LOAD = 22'(1) << C_IR_LOAD;
    localparam logic [21:0] AC_LOAD = 22'(1) << C_AC_LOAD;
    localparam logic [21:0] AC_CLR  = 22'(1) << C_AC_CLEAR;
    localparam logic [21:0] MAR_PC  = 22'(1) << C_MAR_FROM_PC;
    localparam logic [21:0] MDR_AC  = 22'(1) << C_MDR_FROM_AC;
    localparam logic [21:0] MEM_RD  = 22'(1) << C_MEM_READ;
    localparam logic [21:0] MEM_WR  = 22'(1) << C_MEM_WRITE;
    localparam logic [21:0] AC_INC  = 22'(1) << C_AC_INC;

    typedef struct packed {
        logic          ir15, ir14, ac15, wt, req, we, er;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: architectural registers plus an outstanding-transaction record.
    logic [AW-1:0] m_pc, m_mar, m_ah;
    logic [15:0]   m_ir, m_ac, m_mdr, m_wh;
    bit            m_busy, m_wr, m_err;
    int            m_busy_cycles;

    function automatic logic [15:0] alu(input int op, input logic [15:0] a, input logic [15:0] m);
        case (op)
            0: return m;
            1: return a + m;
            2: return a - m;
            3: return a & m;
            4: return a | m;
            5: return a ^ m;
            6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = '0; m_mar = '0; m_ah = '0; m_ir = '0; m_ac = '0; m_mdr = '0; m_wh = '0;
        m_busy = 0; m_wr = 0; m_err = 0; m_busy_cycles = 0;
    endtask

    task automatic model_step(input logic [21:0] c, input bit ack, input logic [15:0] rdata);
        logic [AW-1:0] npc, nmar;
        logic [15:0]   nir, nac, nmdr;
        npc  = c[C_PC_LOAD] ? m_ir[AW-1:0] : (c[C_PC_INC] ? m_pc + 1'b1 : m_pc);
        nmar = c[C_MAR_FROM_IR] ? m_ir[AW-1:0] : (c[C_MAR_FROM_PC] ? m_pc : m_mar);
        nir  = c[C_IR_LOAD] ? m_mdr : m_ir;
        if (c[C_AC_CLEAR])     nac = 16'd0;
        else if (c[C_AC_LOAD]) nac = alu(int'(c[C_ALU_HI:C_ALU_LO]), m_ac, m_mdr);
        else if (c[C_AC_SHL])  nac = m_ac << 1;
        else if (c[C_AC_SHR])  nac = m_ac >> 1;
        else if (c[C_AC_INC])  nac = m_ac + 16'd1;
        else                   nac = m_ac;
        if (m_busy && !m_wr && ack) nmdr = rdata;
        else if (c[C_MDR_FROM_AC])  nmdr = m_ac;
        else                        nmdr = m_mdr;
        if (!m_busy) begin
            if (c[C_MEM_READ] && c[C_MEM_WRITE]) m_err = 1;
            else if (c[C_MEM_READ] || c[C_MEM_WRITE]) begin
                m_busy = 1; m_wr = c[C_MEM_WRITE]; m_ah = m_mar; m_wh = m_mdr; m_busy_cycles = 0;
            end
        end else begin
            m_busy_cycles++;
            if (ack) m_busy = 0;
`ifdef DATAPATH_MEM_TIMEOUT_EN
            else if (m_busy_cycles == 255) begin m_busy = 0; m_err = 1; end
`endif
        end
        m_pc = npc; m_mar = nmar; m_ir = nir; m_ac = nac; m_mdr = nmdr;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ir15 = m_ir[15]; e.ir14 = m_ir[14]; e.ac15 = m_ac[15];
        e.wt = m_busy; e.req = m_busy; e.we = m_busy && m_wr; e.er = m_err;
        e.addr  = m_busy ? m_ah : m_mar;
        e.wdata = m_busy ? m_wh : m_mdr;
        return e;
    endfunction

    // One clock cycle: drive at negedge, optionally pulse reset between edges, predict.
    task automatic cycle(input logic [21:0] c, input bit ack, input logic [15:0] rdata,
                         input bit pulse, input bit hold_rst);
        @(negedge clk);
        bc = c;
        mem_if.mem_ack   = ack;
        mem_if.mem_rdata = rdata;
        if (hold_rst) begin
            reset = 1'b1;
            model_reset();
        end else begin
            reset = 1'b0;
            if (pulse) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
                model_reset();
            end
            model_step(c, ack, rdata);
        end
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input logic [21:0] c);
        cycle(c, 0, 16'h0, 0, 0);
    endtask

    task automatic do_read(input logic [15:0] d, input int lat);
        idle(MEM_RD);
        for (int i = 1; i < lat; i++) idle('0);
        cycle('0, 1, d, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("IR15",      16'(IR15),             16'(e.ir15));
                chk("IR14",      16'(IR14),             16'(e.ir14));
                chk("AC15",      16'(AC15),             16'(e.ac15));
                chk("wait_",     16'(wait_),            16'(e.wt));
                chk("mem_req",   16'(mem_if.mem_req),   16'(e.req));
                chk("mem_we",    16'(mem_if.mem_we),    16'(e.we));
                chk("err",       16'(err),              16'(e.er));
                chk("mem_addr",  16'(mem_if.mem_addr),  16'(e.addr));
                chk("mem_wdata", mem_if.mem_wdata,      e.wdata);
            end
        end
    end

    initial begin : driver
        logic [21:0] c;
        int          rw;
        bit          ack;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 16'h0;
        model_reset();

        // Reset state
        cycle('0, 0, 16'h0, 0, 1);
        cycle('0, 0, 16'h0, 0, 1);
        idle('0);
        idle('0);

        // Read from address 5, ack on the third busy cycle, then decode IR
        for (int i = 0; i < 5; i++) idle(PC_INC);
        idle(MAR_PC);
        do_read(16'hC123, 3);
        idle(IR_LOAD);
        idle('0);

        // ALU add overflow and subtract
        do_read(16'h7FFF, 2);
        idle(AC_LOAD | (22'(0) << C_ALU_LO));
        do_read(16'h0001, 1);
        idle(AC_LOAD | (22'(1) << C_ALU_LO));
        idle(MDR_AC);
        do_read(16'h7FFF, 2);
        idle(AC_LOAD | (22'(0) << C_ALU_LO));
        do_read(16'h0001, 4);
        idle(AC_LOAD | (22'(2) << C_ALU_LO));
        idle(MDR_AC);

        // PC wrap and priorities
        do_read(16'hFFFF, 2);
        idle(IR_LOAD);
        idle(PC_LOAD);
        idle(PC_INC);
        idle(MAR_PC);
        do_read(16'h0ABC, 2);
        idle(IR_LOAD);
        idle(PC_LOAD | PC_INC);
        idle(MAR_PC);
        idle(AC_INC);
        idle(AC_CLR | AC_INC);
        idle(MDR_AC);

        // Conflicts, write during read, ack while idle, async reset mid-read
        idle(MEM_RD | MEM_WR);
        idle('0);
        cycle('0, 0, 16'h0, 1, 0);
        idle(MEM_RD);
        idle(MEM_WR);
        idle('0);
        cycle('0, 1, 16'h1234, 0, 0);
        cycle('0, 1, 16'h5555, 0, 0);
        idle(MDR_AC);
        idle(MEM_WR);
        cycle(MDR_AC, 0, 16'h0, 0, 0);
        cycle('0, 1, 16'h0, 0, 0);
        idle(MEM_RD);
        idle('0);
        cycle('0, 0, 16'h0, 1, 0);
        idle('0);

`ifdef DATAPATH_MEM_TIMEOUT_EN
        // Unanswered read aborts after 255 busy cycles
        idle(MEM_RD);
        for (int i = 0; i < 260; i++) idle('0);
        cycle('0, 0, 16'h0, 1, 0);
        idle(MEM_WR);
        for (int i = 0; i < 100; i++) idle('0);
        cycle('0, 0, 16'h0, 1, 0);
        do_read(16'h2468, 254);
        idle(MDR_AC);
`endif

        // Randomized control words and ack timing
        for (int i = 0; i < 1500; i++) begin
            c  = 22'($urandom);
            rw = $urandom_range(0, 63);
            c[C_MEM_READ]  = (rw < 4) || (rw == 8);
            c[C_MEM_WRITE] = (rw >= 4 && rw < 9);
            ack = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            cycle(c, ack, 16'($urandom), $urandom_range(0, 99) == 0, 0);
        end
        idle('0);

        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
